hd44780_delay_timer: RTL and testbench
======================================

Name: hd44780_delay_timer

Overview:
- Parametrised delay timer for the HD44780 controller state machine.
- Delays are loaded in microsecond-scale ticks; the tick length is derived from the system clock frequency, so LCD timing constants stay clock-independent.
- Gives a single-cycle expiry pulse plus a busy flag, abort and restart.
- Optionally supports periodic reload for refresh/scan sequencing.

Parameters:
- COUNT_BITS, 16, width of the delay count in ticks (max delay 2^COUNT_BITS-1 ticks).
- CLK_HZ, 48000000, system clock frequency.
- TICK_HZ, 1000000, tick rate. PRESCALE = CLK_HZ/TICK_HZ, integer division. Elaboration error if PRESCALE < 1.

Ports:
- CLK_I  in  1  system clock, rising edge.
- RST_N_I  in  1  asynchronous, active-low reset.
- DAT_I  in  COUNT_BITS  delay in ticks, sampled on start_strobe.
- start_strobe  in  1  load DAT_I and start or restart the timer.
- abort_strobe  in  1  cancel the running delay silently.
- busy  out  1  high while a delay is counting.
- end_strobe  out  1  single-cycle expiry pulse, registered.
- count_o  out  COUNT_BITS  remaining ticks.

Behaviour:
- **Reset:** RST_N_I low asynchronously clears count, prescaler, busy, end_strobe and count_o to 0. Reset mid-count loses the delay; no end_strobe is generated.
- **States:** IDLE and RUN. busy=1 exactly in RUN.
- **Start from any state** (start_strobe sampled high at edge k, DAT_I=N):
  - N>0: enter RUN, count=N, prescaler=PRESCALE-1.
  - N=0: stay or return to IDLE; end_strobe=1 in the cycle after edge k (immediate expiry).
- **RUN, counting:**
  - Prescaler decrements every clock.
  - At 0 it reloads to PRESCALE-1 and count decrements.
  - On count 1->0, at edge k+N*PRESCALE: end_strobe=1 for exactly one cycle, busy=0 in the same cycle, return to IDLE.
- **Restart while busy:** start_strobe in RUN reloads count and prescaler; no end_strobe for the abandoned delay.
- **Abort:** abort_strobe in RUN goes to IDLE with count=0 and no end_strobe. abort_strobe in IDLE has no effect.
- **Simultaneous events:**
  - start and abort together: start wins.
  - start on the expiry edge: start wins, end_strobe suppressed.
- **Arithmetic:** count is unsigned, never wraps below 0. The prescaler is ceil(log2(PRESCALE)) bits, minimum 1. For PRESCALE=1 every clock is a tick.

Optional Feature:
- HD44780_DELAY_TIMER_RELOAD_EN defined:
  - Adds input port periodic (1 bit), sampled together with start_strobe.
  - If latched high and N>0: at each expiry, end_strobe pulses, count reloads the latched N and the prescaler reloads. busy stays 1 until abort_strobe or a new start.
  - Period is exactly N*PRESCALE clocks between end_strobe pulses.
- Macro not defined: no periodic port, one-shot only as above.

Decomposition:
- Package hd44780_timing_pkg:
  - Function prescale_of(CLK_HZ, TICK_HZ).
  - LCD timing constants in microseconds: T_POWERON_US=15000, T_INIT1_US=4100, T_INIT2_US=100, T_CLEAR_US=1640, T_CMD_US=40, T_E_PULSE_US=1.
  - State enum for IDLE/RUN.
- Sub-module hd44780_tick_prescaler:
  - Down-counter with sync clear and a single-cycle tick output.
  - Instantiated once; also reusable by the E-pulse generator.

Test Plan (CLK_HZ=4, TICK_HZ=1, PRESCALE=4, COUNT_BITS=8 unless stated):
- Reset release, start with DAT_I=3 at edge 10 -> busy high from edge 10; count_o steps 3,2,1 every 4 clocks; end_strobe high exactly one cycle at edge 22; busy low at edge 22.
- DAT_I=0 start -> end_strobe one cycle after start; busy never high.
- Start with DAT_I=5, re-start with DAT_I=2 after 6 clocks -> no pulse for the first delay; single end_strobe 8 clocks after the second start.
- Start 4, abort after 5 clocks -> busy drops next edge; no end_strobe over 40 clocks. Separately, start+abort in the same cycle -> timer runs.
- RST_N_I pulsed low asynchronously mid-count (between edges) -> all outputs 0 immediately; no end_strobe after release.
- With HD44780_DELAY_TIMER_RELOAD_EN, periodic=1, DAT_I=2 -> end_strobe every 8 clocks for 5 periods, busy constant 1; abort stops pulses. PRESCALE=1 variant: DAT_I=3 expires after 3 clocks.

Source files
------------

// File: rtl/hd44780_timing_pkg.sv
// Shared timing definitions for the HD44780 controller: prescale helper,
// LCD wait times in microseconds, and the delay timer state encoding.
package hd44780_timing_pkg;

  // LCD command and initialisation waits, expressed in microsecond ticks
  localparam int T_POWERON_US = 15000;
  localparam int T_INIT1_US   = 4100;
  localparam int T_INIT2_US   = 100;
  localparam int T_CLEAR_US   = 1640;
  localparam int T_CMD_US     = 40;
  localparam int T_E_PULSE_US = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

  // Number of system clocks per timer tick; 0 flags an unusable ratio
  function automatic int prescale_of(input int clk_hz, input int tick_hz);
    if (tick_hz <= 0) return 0;
    return clk_hz / tick_hz;
  endfunction

  // Prescaler register width: ceil(log2(prescale)), never below one bit
  function automatic int prescale_width(input int prescale);
    if (prescale <= 2) return 1;
    return $clog2(prescale);
  endfunction

endpackage

// File: rtl/hd44780_tick_prescaler.sv
// Tick prescaler: a down-counter that emits a one-cycle tick each time it
// passes through zero. Shared by the delay timer and the E-pulse generator.
module hd44780_tick_prescaler #(
  parameter int PRESCALE = 48,
  parameter int WIDTH    = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic load_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [WIDTH-1:0] RELOAD = WIDTH'(PRESCALE - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over load; a running counter wraps back to the full period at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = RELOAD;
    end else if (en_i) begin
      if (cnt_q == '0) cnt_d = RELOAD;
      else             cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register with asynchronous reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/hd44780_delay_timer.sv
// HD44780 delay timer: loads a delay in ticks, counts it down at the
// prescaled tick rate and emits a registered one-cycle expiry pulse.
// Optional periodic reload is enabled by defining HD44780_DELAY_TIMER_RELOAD_EN.
module hd44780_delay_timer
  import hd44780_timing_pkg::*;
#(
  parameter int COUNT_BITS = 16,
  parameter int CLK_HZ     = 48000000,
  parameter int TICK_HZ    = 1000000
) (
  input  logic                  CLK_I,
  input  logic                  RST_N_I,
  input  logic [COUNT_BITS-1:0] DAT_I,
  input  logic                  start_strobe,
  input  logic                  abort_strobe,
`ifdef HD44780_DELAY_TIMER_RELOAD_EN
  input  logic                  periodic,
`endif
  output logic                  busy,
  output logic                  end_strobe,
  output logic [COUNT_BITS-1:0] count_o
);

  localparam int PRESCALE = prescale_of(CLK_HZ, TICK_HZ);
  localparam int PRE_W    = prescale_width(PRESCALE);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("hd44780_delay_timer: CLK_HZ/TICK_HZ must be at least 1");
  end

  timer_state_e          state_q, state_d;
  logic [COUNT_BITS-1:0] count_q, count_d;
  logic                  end_q, end_d;
  logic                  pre_clear, pre_load, pre_en, pre_tick;
`ifdef HD44780_DELAY_TIMER_RELOAD_EN
  logic                  periodic_q, periodic_d;
  logic [COUNT_BITS-1:0] reload_q, reload_d;
`endif

  hd44780_tick_prescaler #(
    .PRESCALE (PRESCALE),
    .WIDTH    (PRE_W)
  ) u_prescaler (
    .clk_i   (CLK_I),
    .rst_ni  (RST_N_I),
    .clear_i (pre_clear),
    .load_i  (pre_load),
    .en_i    (pre_en),
    .tick_o  (pre_tick)
  );

  // Next-state logic: start beats abort and expiry, abort beats expiry
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    end_d     = 1'b0;
    pre_clear = 1'b0;
    pre_load  = 1'b0;
    pre_en    = (state_q == ST_RUN);
`ifdef HD44780_DELAY_TIMER_RELOAD_EN
    periodic_d = periodic_q;
    reload_d   = reload_q;
`endif
    if (start_strobe) begin
      if (DAT_I != '0) begin
        state_d  = ST_RUN;
        count_d  = DAT_I;
        pre_load = 1'b1;
      end else begin
        state_d   = ST_IDLE;
        count_d   = '0;
        end_d     = 1'b1;
        pre_clear = 1'b1;
      end
`ifdef HD44780_DELAY_TIMER_RELOAD_EN
      periodic_d = periodic && (DAT_I != '0);
      reload_d   = DAT_I;
`endif
    end else if (state_q == ST_RUN) begin
      if (abort_strobe) begin
        state_d   = ST_IDLE;
        count_d   = '0;
        pre_clear = 1'b1;
      end else if (pre_tick) begin
        if (count_q <= COUNT_BITS'(1)) begin
          end_d = 1'b1;
`ifdef HD44780_DELAY_TIMER_RELOAD_EN
          if (periodic_q) begin
            count_d = reload_q;
          end else begin
            state_d   = ST_IDLE;
            count_d   = '0;
            pre_clear = 1'b1;
          end
`else
          state_d   = ST_IDLE;
          count_d   = '0;
          pre_clear = 1'b1;
`endif
        end else begin
          count_d = count_q - COUNT_BITS'(1);
        end
      end
    end
  end

  // State, count and expiry pulse registers with asynchronous reset
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      end_q   <= end_d;
    end
  end

`ifdef HD44780_DELAY_TIMER_RELOAD_EN
  // Latched reload value and mode for periodic operation
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      periodic_q <= 1'b0;
      reload_q   <= '0;
    end else begin
      periodic_q <= periodic_d;
      reload_q   <= reload_d;
    end
  end
`endif

  assign busy       = (state_q == ST_RUN);
  assign end_strobe = end_q;
  assign count_o    = count_q;

endmodule

// File: tb/tb_hd44780_delay_timer.sv
// Directed bench for hd44780_delay_timer at PRESCALE=4, COUNT_BITS=8, plus a
// PRESCALE=1 instance. Exercises periodic reload when
// HD44780_DELAY_TIMER_RELOAD_EN is defined.
module tb_hd44780_delay_timer;

  logic       clk;
  logic       rstN;
  logic [7:0] dat;
  logic       startS;
  logic       abortS;
  logic       busy;
  logic       endS;
  logic [7:0] count;

  logic [7:0] fDat;
  logic       fStart;
  logic       fAbort;
  logic       fBusy;
  logic       fEnd;
  logic [7:0] fCount;

`ifdef HD44780_DELAY_TIMER_RELOAD_EN
  logic       periodic;
  logic       fPeriodic;
`endif

  int totalChecks = 0;
  int badChecks   = 0;

  hd44780_delay_timer #(.COUNT_BITS(8), .CLK_HZ(4), .TICK_HZ(1)) dut (
    .CLK_I        (clk),
    .RST_N_I      (rstN),
    .DAT_I        (dat),
    .start_strobe (startS),
    .abort_strobe (abortS),
`ifdef HD44780_DELAY_TIMER_RELOAD_EN
    .periodic     (periodic),
`endif
    .busy         (busy),
    .end_strobe   (endS),
    .count_o      (count)
  );

  hd44780_delay_timer #(.COUNT_BITS(8), .CLK_HZ(1), .TICK_HZ(1)) dutFast (
    .CLK_I        (clk),
    .RST_N_I      (rstN),
    .DAT_I        (fDat),
    .start_strobe (fStart),
    .abort_strobe (fAbort),
`ifdef HD44780_DELAY_TIMER_RELOAD_EN
    .periodic     (fPeriodic),
`endif
    .busy         (fBusy),
    .end_strobe   (fEnd),
    .count_o      (fCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of strobes and data, leave the bench 1 time unit past the edge
  task automatic applyStimulus(input logic s, input logic a, input logic [7:0] d);
    startS = s;
    abortS = a;
    dat    = d;
    @(posedge clk);
    #1;
    startS = 1'b0;
    abortS = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #12;
    totalChecks++;
    if (busy !== 1'b0 || endS !== 1'b0 || count !== 8'd0) begin
      badChecks++;
      $display("[TB] FAIL reset_state busy=%b end=%b count=%0d want 0/0/0", busy, endS, count);
    end
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_oneshot();
    logic [7:0] expCount;
    applyStimulus(1'b1, 1'b0, 8'd3);
    totalChecks++;
    if (busy !== 1'b1 || count !== 8'd3 || endS !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL oneshot_start busy=%b count=%0d end=%b want 1/3/0", busy, count, endS);
    end
    for (int j = 1; j <= 13; j++) begin
      applyStimulus(1'b0, 1'b0, 8'd0);
      expCount = (j < 12) ? 8'(3 - j / 4) : 8'd0;
      totalChecks++;
      if (count !== expCount || endS !== (j == 12) || busy !== (j < 12)) begin
        badChecks++;
        $display("[TB] FAIL oneshot_run j=%0d count=%0d end=%b busy=%b want %0d/%b/%b",
                 j, count, endS, busy, expCount, (j == 12), (j < 12));
      end
    end
  endtask

  task automatic test_zero_delay();
    applyStimulus(1'b1, 1'b0, 8'd0);
    totalChecks++;
    if (endS !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
      badChecks++;
      $display("[TB] FAIL zero_expiry end=%b busy=%b count=%0d want 1/0/0", endS, busy, count);
    end
    applyStimulus(1'b0, 1'b0, 8'd0);
    totalChecks++;
    if (endS !== 1'b0 || busy !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL zero_after end=%b busy=%b want 0/0", endS, busy);
    end
  endtask

  task automatic test_restart();
    applyStimulus(1'b1, 1'b0, 8'd5);
    for (int j = 1; j <= 6; j++) applyStimulus(1'b0, 1'b0, 8'd0);
    totalChecks++;
    if (busy !== 1'b1 || count !== 8'd4) begin
      badChecks++;
      $display("[TB] FAIL restart_mid busy=%b count=%0d want 1/4", busy, count);
    end
    applyStimulus(1'b1, 1'b0, 8'd2);
    totalChecks++;
    if (count !== 8'd2 || busy !== 1'b1) begin
      badChecks++;
      $display("[TB] FAIL restart_load count=%0d busy=%b want 2/1", count, busy);
    end
    for (int j = 1; j <= 14; j++) begin
      applyStimulus(1'b0, 1'b0, 8'd0);
      totalChecks++;
      if (endS !== (j == 8) || busy !== (j < 8)) begin
        badChecks++;
        $display("[TB] FAIL restart_run j=%0d end=%b busy=%b want %b/%b",
                 j, endS, busy, (j == 8), (j < 8));
      end
    end
  endtask

  task automatic test_abort();
    applyStimulus(1'b1, 1'b0, 8'd4);
    for (int j = 1; j <= 4; j++) applyStimulus(1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'd0);
    totalChecks++;
    if (busy !== 1'b0 || count !== 8'd0 || endS !== 1'b0) begin
      badChecks++;
      $display("[TB] FAIL abort_drop busy=%b count=%0d end=%b want 0/0/0", busy, count, endS);
    end
    for (int j = 1; j <= 40; j++) begin
      applyStimulus(1'b0, 1'b0, 8'd0);
      totalChecks++;
      if (endS !== 1'b0 || busy !== 1'b0) begin
        badChecks++;
        $display("[TB] FAIL abort_quiet j=%0d end=%b busy=%b want 0/0", j, endS, busy);
      end
    end
    applyStimulus(1'b1, 1'b1, 8'd2);
    totalChecks++;
    if (busy !== 1'b1 || count !== 8'd2) begin
      badChecks++;
      $display("[TB] FAIL start_abort_same busy=%b count=%0d want 1/2", busy, count);
    end
    for (int j = 1; j <= 9; j++) begin
      applyStimulus(1'b0, 1'b0, 8'd0);
      totalChecks++;
      if (endS !== (j == 8) || busy !== (j < 8)) begin
        badChecks++;
        $display("[TB] FAIL start_abort_run j=%0d end=%b busy=%b want %b/%b",
                 j, endS, busy, (j == 8), (j < 8));
      end
    end
  endtask

  task automatic test_start_on_expiry();
    applyStimulus(1'b1, 1'b0, 8'd1);
    for (int j = 1; j <= 3; j++) applyStimulus(1'b0, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b0, 8'd2);
    totalChecks++;
    if (endS !== 1'b0 || busy !== 1'b1 || count !== 8'd2) begin
      badChecks++;
      $display("[TB] FAIL expiry_start end=%b busy=%b count=%0d want 0/1/2", endS, busy, count);
    end
    for (int j = 1; j <= 9; j++) begin
      applyStimulus(1'b0, 1'b0, 8'd0);
      totalChecks++;
      if (endS !== (j == 8) || busy !== (j < 8)) begin
        badChecks++;
        $display("[TB] FAIL expiry_start_run j=%0d end=%b busy=%b want %b/%b",
                 j, endS, busy, (j == 8), (j < 8));
      end
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(1'b1, 1'b0, 8'd3);
    for (int j = 1; j <= 5; j++) applyStimulus(1'b0, 1'b0, 8'd0);
    #2;
    rstN = 1'b0;
    #1;
    totalChecks++;
    if (busy !== 1'b0 || endS !== 1'b0 || count !== 8'd0) begin
      badChecks++;
      $display("[TB] FAIL async_reset busy=%b end=%b count=%0d want 0/0/0", busy, endS, count);
    end
    #3;
    rstN = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      applyStimulus(1'b0, 1'b0, 8'd0);
      totalChecks++;
      if (endS !== 1'b0 || busy !== 1'b0) begin
        badChecks++;
        $display("[TB] FAIL reset_quiet j=%0d end=%b busy=%b want 0/0", j, endS, busy);
      end
    end
  endtask

  task automatic test_prescale_one();
    logic [7:0] expCount;
    fDat   = 8'd3;
    fStart = 1'b1;
    @(posedge clk);
    #1;
    fStart = 1'b0;
    totalChecks++;
    if (fBusy !== 1'b1 || fCount !== 8'd3) begin
      badChecks++;
      $display("[TB] FAIL fast_start busy=%b count=%0d want 1/3", fBusy, fCount);
    end
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk);
      #1;
      expCount = (j < 3) ? 8'(3 - j) : 8'd0;
      totalChecks++;
      if (fCount !== expCount || fEnd !== (j == 3) || fBusy !== (j < 3)) begin
        badChecks++;
        $display("[TB] FAIL fast_run j=%0d count=%0d end=%b busy=%b want %0d/%b/%b",
                 j, fCount, fEnd, fBusy, expCount, (j == 3), (j < 3));
      end
    end
  endtask

`ifdef HD44780_DELAY_TIMER_RELOAD_EN
  task automatic test_periodic();
    periodic = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'd2);
    periodic = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      applyStimulus(1'b0, 1'b0, 8'd0);
      totalChecks++;
      if (endS !== (j % 8 == 0) || busy !== 1'b1) begin
        badChecks++;
        $display("[TB] FAIL periodic_run j=%0d end=%b busy=%b want %b/1", j, endS, busy, (j % 8 == 0));
      end
    end
    applyStimulus(1'b0, 1'b1, 8'd0);
    for (int j = 1; j <= 16; j++) begin
      applyStimulus(1'b0, 1'b0, 8'd0);
      totalChecks++;
      if (endS !== 1'b0 || busy !== 1'b0) begin
        badChecks++;
        $display("[TB] FAIL periodic_abort j=%0d end=%b busy=%b want 0/0", j, endS, busy);
      end
    end
  endtask
`endif

  // Run every scenario in order, then report totals
  initial begin
    dat    = 8'd0;
    startS = 1'b0;
    abortS = 1'b0;
    fDat   = 8'd0;
    fStart = 1'b0;
    fAbort = 1'b0;
`ifdef HD44780_DELAY_TIMER_RELOAD_EN
    periodic  = 1'b0;
    fPeriodic = 1'b0;
`endif
    test_reset();
    for (int j = 0; j < 8; j++) applyStimulus(1'b0, 1'b0, 8'd0);
    test_oneshot();
    test_zero_delay();
    test_restart();
    test_abort();
    test_start_on_expiry();
    test_async_reset();
    test_prescale_one();
`ifdef HD44780_DELAY_TIMER_RELOAD_EN
    test_periodic();
`endif
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
